// File: rtl/dram_request_arbiter.sv
// Shares one DRAM memrequest port between NUM_REQ requesters and returns read data in issue order.
// Build option: define DRAM_ARB_ROUND_ROBIN_EN for round-robin grants (default is fixed priority).
module dram_request_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 128,
   parameter int USER_W    = 38,
   parameter int TRK_DEPTH = 64
) (
   input  logic                       clk_dram_ctrl,
   input  logic                       rst_dram_ctrl_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ-1:0]         req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   input  logic [NUM_REQ*USER_W-1:0]  req_user,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [DATA_W-1:0]          rsp_data,
   output logic [USER_W-1:0]          rsp_user,
   output logic                       rsp_orphan_err,
   output logic [$clog2(TRK_DEPTH):0] trk_count,
   output logic [ADDR_W-1:0]          memrequest_addr,
   output logic                       memrequest_en,
   output logic [DATA_W-1:0]          memrequest_write_data,
   output logic                       memrequest_write_enable,
   input  logic                       memrequest_write_ready,
   input  logic                       memrequest_busy,
   input  logic                       memrequest_read_valid,
   input  logic [DATA_W-1:0]          memrequest_read_data
);
   localparam int PTR_W = $clog2(TRK_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ID_W  = $clog2(NUM_REQ);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              orphan_q, orphan_d;
   logic [ID_W-1:0]   trk_id_q   [TRK_DEPTH];
   logic [USER_W-1:0] trk_user_q [TRK_DEPTH];

   logic [NUM_REQ-1:0] elig_s;
   logic               grant_vld_s;
   logic [ID_W-1:0]    grant_id_s;
   logic               push_s;
   logic               pop_s;
   logic               full_s;
   logic               empty_s;
   logic [USER_W-1:0]  push_user_s;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W:0]      rr_sum_s;
`endif

   assign full_s  = (count_q == CNT_W'(TRK_DEPTH));
   assign empty_s = (count_q == {CNT_W{1'b0}});
   // A response pops the head even when the tracker is full, which frees a slot for a read this cycle.
   assign pop_s   = rst_dram_ctrl_n & memrequest_read_valid & ~empty_s;

   // Per-port eligibility and grant selection
   always_comb begin
      elig_s      = '0;
      grant_id_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig_s[i] = rst_dram_ctrl_n & req_valid[i] & ~memrequest_busy &
                     (req_write[i] ? memrequest_write_ready : (~full_s | pop_s));
      end
      grant_vld_s = |elig_s;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      // Walk from the farthest offset back to the pointer so the pointer position wins last.
      rr_sum_s = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         rr_sum_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (rr_sum_s >= (ID_W+1)'(NUM_REQ)) begin
            rr_sum_s = rr_sum_s - (ID_W+1)'(NUM_REQ);
         end else begin
            rr_sum_s = rr_sum_s;
         end
         grant_id_s = elig_s[rr_sum_s[ID_W-1:0]] ? rr_sum_s[ID_W-1:0] : grant_id_s;
      end
`else
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         grant_id_s = elig_s[i] ? ID_W'(i) : grant_id_s;
      end
`endif
   end

   // Drive the memrequest port from the granted requester
   always_comb begin
      req_ready               = '0;
      memrequest_en           = 1'b0;
      memrequest_write_enable = 1'b0;
      memrequest_addr         = '0;
      memrequest_write_data   = '0;
      push_s                  = 1'b0;
      push_user_s             = '0;
      if (grant_vld_s) begin
         req_ready[grant_id_s]   = 1'b1;
         memrequest_en           = 1'b1;
         memrequest_write_enable = req_write[grant_id_s];
         memrequest_addr         = req_addr[grant_id_s*ADDR_W +: ADDR_W];
         memrequest_write_data   = req_wdata[grant_id_s*DATA_W +: DATA_W];
         push_s                  = ~req_write[grant_id_s];
         push_user_s             = req_user[grant_id_s*USER_W +: USER_W];
      end else begin
         req_ready               = '0;
      end
   end

   // Tracker pointer, occupancy and orphan next-state
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      orphan_d = orphan_q | (memrequest_read_valid & empty_s);
   end

   // Response steering from the tracker head
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_user  = '0;
      if (pop_s) begin
         rsp_valid = NUM_REQ'(1'b1) << trk_id_q[rd_ptr_q];
         rsp_data  = memrequest_read_data;
         rsp_user  = trk_user_q[rd_ptr_q];
      end else begin
         rsp_valid = '0;
      end
   end

   // Tracker control registers
   always_ff @(posedge clk_dram_ctrl) begin
      if (!rst_dram_ctrl_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         orphan_q <= orphan_d;
      end
   end

   // Tracker storage; contents are meaningless outside the valid window so no reset
   always_ff @(posedge clk_dram_ctrl) begin
      if (push_s) begin
         trk_id_q[wr_ptr_q]   <= grant_id_s;
         trk_user_q[wr_ptr_q] <= push_user_s;
      end
   end

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   // Round-robin pointer next-state: one past the last granted port
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld_s) begin
         rr_ptr_d = (grant_id_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (grant_id_s + ID_W'(1));
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk_dram_ctrl) begin
      if (!rst_dram_ctrl_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   assign trk_count      = count_q;
   assign rsp_orphan_err = orphan_q;

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Directed bench for dram_request_arbiter: vector table for grant logic plus tracker sequences.
module tb_dram_request_arbiter;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 128;
   localparam int USER_W = 38;
   localparam logic [DATA_W-1:0] WD0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
   localparam logic [DATA_W-1:0] WD1 = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
   localparam logic [DATA_W-1:0] D1  = 128'h1111_0000_2222_0000_3333_0000_4444_0001;
   localparam logic [DATA_W-1:0] D2  = 128'h5555_0000_6666_0000_7777_0000_8888_0002;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [1:0]          req_valid, req_ready, req_write, rsp_valid;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [2*USER_W-1:0] req_user;
   logic [DATA_W-1:0]   rsp_data;
   logic [USER_W-1:0]   rsp_user;
   logic                rsp_orphan_err;
   logic [6:0]          trk_count;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_en, mem_we;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_wr_ready, mem_busy, mem_rd_valid;
   logic [DATA_W-1:0]   mem_rd_data;

   logic [2:0]          r_valid, r_ready, r_write, r_rsp_valid;
   logic [3*ADDR_W-1:0] r_addr;
   logic [3*DATA_W-1:0] r_wdata;
   logic [3*USER_W-1:0] r_user;
   logic [DATA_W-1:0]   r_rsp_data;
   logic [USER_W-1:0]   r_rsp_user;
   logic                r_orphan;
   logic [6:0]          r_count;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_en, r_mem_we;
   logic [DATA_W-1:0]   r_mem_wdata;

   dram_request_arbiter #(.NUM_REQ(2)) u_dut (
      .clk_dram_ctrl(clk), .rst_dram_ctrl_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_user(rsp_user),
      .rsp_orphan_err(rsp_orphan_err), .trk_count(trk_count),
      .memrequest_addr(mem_addr), .memrequest_en(mem_en),
      .memrequest_write_data(mem_wdata), .memrequest_write_enable(mem_we),
      .memrequest_write_ready(mem_wr_ready), .memrequest_busy(mem_busy),
      .memrequest_read_valid(mem_rd_valid), .memrequest_read_data(mem_rd_data)
   );

   dram_request_arbiter #(.NUM_REQ(3)) u_dut3 (
      .clk_dram_ctrl(clk), .rst_dram_ctrl_n(rst_n),
      .req_valid(r_valid), .req_ready(r_ready), .req_write(r_write),
      .req_addr(r_addr), .req_wdata(r_wdata), .req_user(r_user),
      .rsp_valid(r_rsp_valid), .rsp_data(r_rsp_data), .rsp_user(r_rsp_user),
      .rsp_orphan_err(r_orphan), .trk_count(r_count),
      .memrequest_addr(r_mem_addr), .memrequest_en(r_mem_en),
      .memrequest_write_data(r_mem_wdata), .memrequest_write_enable(r_mem_we),
      .memrequest_write_ready(mem_wr_ready), .memrequest_busy(mem_busy),
      .memrequest_read_valid(mem_rd_valid), .memrequest_read_data(mem_rd_data)
   );

   typedef struct {
      logic [1:0]        valid;
      logic [1:0]        write;
      logic              busy;
      logic              wr_rdy;
      logic [1:0]        exp_ready;
      logic              exp_en;
      logic              exp_we;
      logic [ADDR_W-1:0] exp_addr;
      logic [DATA_W-1:0] exp_wdata;
      logic [6:0]        exp_cnt;
   } vec_t;

   vec_t vecs [9];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [2:0] exp_rr;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      req_valid    = 2'b00;
      r_valid      = 3'b000;
      mem_rd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // valid, write, busy, wr_rdy | ready, en, we, addr, wdata, count before edge
      vecs[0] = '{2'b11, 2'b10, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 24'h000010, WD0,    7'd0};
      vecs[1] = '{2'b10, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 24'h000020, WD1,    7'd1};
      vecs[2] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 128'h0, 7'd1};
      vecs[3] = '{2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 24'h000000, 128'h0, 7'd1};
      vecs[4] = '{2'b11, 2'b01, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 24'h000020, WD1,    7'd1};
      vecs[5] = '{2'b11, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 24'h000010, WD0,    7'd2};
      vecs[6] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 128'h0, 7'd2};
      vecs[7] = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 24'h000010, WD0,    7'd2};
      vecs[8] = '{2'b10, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 24'h000020, WD1,    7'd3};

      rst_n        = 1'b0;
      req_valid    = 2'b11;
      req_write    = 2'b00;
      req_addr     = {24'h000020, 24'h000010};
      req_wdata    = {WD1, WD0};
      req_user     = {38'd9, 38'd5};
      mem_busy     = 1'b0;
      mem_wr_ready = 1'b1;
      mem_rd_valid = 1'b1;
      mem_rd_data  = D1;
      r_valid      = 3'b000;
      r_write      = 3'b000;
      r_addr       = {24'h000300, 24'h000200, 24'h000100};
      r_wdata      = '0;
      r_user       = {38'd3, 38'd2, 38'd1};

      // Requests and a response presented during reset must all be suppressed
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", 128'(req_ready), 128'(2'b00));
      check("rst_en", 128'(mem_en), 128'(1'b0));
      check("rst_we", 128'(mem_we), 128'(1'b0));
      check("rst_rsp_valid", 128'(rsp_valid), 128'(2'b00));
      check("rst_cnt", 128'(trk_count), 128'(7'd0));
      check("rst_orphan", 128'(rsp_orphan_err), 128'(1'b0));
      @(negedge clk);
      rst_n        = 1'b1;
      req_valid    = 2'b00;
      mem_rd_valid = 1'b0;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         req_valid    = vecs[i].valid;
         req_write    = vecs[i].write;
         mem_busy     = vecs[i].busy;
         mem_wr_ready = vecs[i].wr_rdy;
         #1;
         check($sformatf("v%0d_ready", i), 128'(req_ready), 128'(vecs[i].exp_ready));
         check($sformatf("v%0d_en", i), 128'(mem_en), 128'(vecs[i].exp_en));
         check($sformatf("v%0d_we", i), 128'(mem_we), 128'(vecs[i].exp_we));
         check($sformatf("v%0d_addr", i), 128'(mem_addr), 128'(vecs[i].exp_addr));
         check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
         check($sformatf("v%0d_cnt", i), 128'(trk_count), 128'(vecs[i].exp_cnt));
      end
      @(negedge clk);
      req_valid    = 2'b00;
      mem_busy     = 1'b0;
      mem_wr_ready = 1'b1;
      #1;
      check("tbl_end_cnt", 128'(trk_count), 128'(7'd3));

      // In-order response routing back to the issuing port with its tag
      do_reset();
      req_write = 2'b00;
      @(negedge clk); req_valid = 2'b01; #1;
      check("t2_rd0_ready", 128'(req_ready), 128'(2'b01));
      @(negedge clk); req_valid = 2'b10; #1;
      check("t2_rd1_ready", 128'(req_ready), 128'(2'b10));
      @(negedge clk); req_valid = 2'b00; mem_rd_valid = 1'b1; mem_rd_data = D1; #1;
      check("t2_cnt2", 128'(trk_count), 128'(7'd2));
      check("t2_rsp1_valid", 128'(rsp_valid), 128'(2'b01));
      check("t2_rsp1_data", rsp_data, D1);
      check("t2_rsp1_user", 128'(rsp_user), 128'(38'd5));
      @(negedge clk); mem_rd_data = D2; #1;
      check("t2_rsp2_valid", 128'(rsp_valid), 128'(2'b10));
      check("t2_rsp2_data", rsp_data, D2);
      check("t2_rsp2_user", 128'(rsp_user), 128'(38'd9));
      @(negedge clk); mem_rd_valid = 1'b0; #1;
      check("t2_idle_rsp", 128'(rsp_valid), 128'(2'b00));
      check("t2_cnt0", 128'(trk_count), 128'(7'd0));
      check("t2_no_orphan", 128'(rsp_orphan_err), 128'(1'b0));

      // Fill the tracker, then a simultaneous pop lets one more read in
      do_reset();
      begin
         int acc;
         acc = 0;
         for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            req_valid = 2'b01;
            req_user[USER_W-1:0] = USER_W'(k);
            #1;
            if (req_ready == 2'b01) acc++;
         end
         check("t3_accepted", 128'(acc), 128'(64));
      end
      @(negedge clk); req_user[USER_W-1:0] = 38'd64; #1;
      check("t3_full_cnt", 128'(trk_count), 128'(7'd64));
      check("t3_full_ready", 128'(req_ready), 128'(2'b00));
      check("t3_full_en", 128'(mem_en), 128'(1'b0));
      mem_rd_valid = 1'b1; mem_rd_data = D1; #1;
      check("t3_pp_ready", 128'(req_ready), 128'(2'b01));
      check("t3_pp_rsp", 128'(rsp_valid), 128'(2'b01));
      check("t3_pp_user", 128'(rsp_user), 128'(38'd0));
      @(negedge clk); req_valid = 2'b00; #1;
      check("t3_pp_cnt", 128'(trk_count), 128'(7'd64));
      for (int k = 1; k <= 64; k++) begin
         if (k != 1) begin @(negedge clk); #1; end
         check($sformatf("t3_pop%0d_user", k), 128'(rsp_user), 128'(k));
      end
      @(negedge clk); mem_rd_valid = 1'b0; #1;
      check("t3_drained_cnt", 128'(trk_count), 128'(7'd0));
      check("t3_drained_orphan", 128'(rsp_orphan_err), 128'(1'b0));

      // Reads forgotten by a reset come back as orphans
      do_reset();
      repeat (3) begin @(negedge clk); req_valid = 2'b01; end
      @(negedge clk); req_valid = 2'b00; #1;
      check("t5_cnt3", 128'(trk_count), 128'(7'd3));
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); mem_rd_valid = 1'b1; #1;
         check($sformatf("t5_orphan_rsp%0d", k), 128'(rsp_valid), 128'(2'b00));
      end
      @(negedge clk); mem_rd_valid = 1'b0; #1;
      check("t5_orphan_set", 128'(rsp_orphan_err), 128'(1'b1));
      check("t5_cnt0", 128'(trk_count), 128'(7'd0));
      repeat (3) @(negedge clk);
      #1;
      check("t5_orphan_sticky", 128'(rsp_orphan_err), 128'(1'b1));
      do_reset();
      #1;
      check("t5_orphan_cleared", 128'(rsp_orphan_err), 128'(1'b0));

      // Three ports held valid: grant sequence depends on the arbitration build
      do_reset();
      r_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         if (k != 0) @(negedge clk);
         #1;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
         exp_rr = 3'b001 << (k % 3);
`else
         exp_rr = 3'b001;
`endif
         check($sformatf("t6_grant%0d", k), 128'(r_ready), 128'(exp_rr));
      end
      @(negedge clk); r_valid = 3'b000;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
